muldiv_sequencer: RTL and testbench

- Iterative signed multiply/divide engine with its own sequencer; owns the Hi/Lo result pair for MULT/DIV.
- Started by one-cycle requests from control_unit; operands come from A_out/B_out.
- Reports busy while running, then a one-cycle done with Hi/Lo write strobe.
- Reports a one-cycle div_zero so control_unit can take the divide-by-zero exception path.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit holding the Hi/Lo result pair.
// Radix-2 Booth multiply and restoring divide, one step per clock, 32 steps each.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_write,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FINISH,
        S_DZERO
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               last_step;

    // The accumulator is one bit wider than the operands so that adding or
    // subtracting the most negative multiplicand cannot overflow mid-Booth.
    always_comb begin
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        booth_sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        last_step = (cnt_q == CNT_W'(WIDTH));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        mcand_d   = mcand_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (mult_start) begin
                    acc_d   = '0;
                    q_d     = op_b;
                    q1_d    = 1'b0;
                    mcand_d = op_a;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end else if (div_start) begin
                    if (op_b == '0) begin
                        state_d = S_DZERO;
                    end else begin
                        acc_d     = '0;
                        q_d       = op_a[WIDTH-1] ? -op_a : op_a;
                        mcand_d   = op_b[WIDTH-1] ? -op_b : op_b;
                        neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_rem_d = op_a[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = S_DIV;
                    end
                end
            end
            S_MULT: begin
                if (last_step) begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = q_q;
                    state_d = S_FINISH;
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                // Magnitudes were divided; signs are applied as the result is committed.
                if (last_step) begin
                    lo_d    = neg_quo_q ? -q_q : q_q;
                    hi_d    = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    state_d = S_FINISH;
                end else begin
                    if (div_trial[WIDTH]) begin
                        acc_d = div_shift;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = div_trial;
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_DZERO:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            mcand_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            mcand_q   <= mcand_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == S_MULT) || (state_q == S_DIV);
    assign done        = (state_q == S_FINISH);
    assign hi_lo_write = (state_q == S_FINISH);
    assign div_zero    = (state_q == S_DZERO);
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: signed multiply/divide results, latency,
// divide-by-zero, reset abort, simultaneous starts and back-to-back operation.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        hi_lo_write;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int compared;
    int mismatched;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .hi_lo_write (hi_lo_write),
        .div_zero    (div_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start, then watches up to 40 cycles for done; lat is the number
    // of edges after acceptance at which done is seen (-1 if never).
    task automatic runOp(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         output int lat, output int busyCnt, output int hlwBad,
                         output int dzSeen, output int dzAt);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        lat     = -1;
        busyCnt = 0;
        hlwBad  = 0;
        dzSeen  = 0;
        dzAt    = -1;
        for (int k = 0; k <= 40; k++) begin
            if (poke && k == 5) begin
                mult_start = 1'b1;
                div_start  = 1'b1;
                op_a       = 32'd9;
                op_b       = 32'd9;
            end
            if (poke && k == 7) begin
                mult_start = 1'b0;
                div_start  = 1'b0;
            end
            if (busy) busyCnt++;
            if (hi_lo_write !== done) hlwBad++;
            if (div_zero) begin
                dzSeen++;
                if (dzAt < 0) dzAt = k;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, done, hi_lo_write, div_zero} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags got %b want 0000", {busy, done, hi_lo_write, div_zero});
        end
        compared++;
        if ({hi_out, lo_out} !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hilo got %h/%h want 0/0", hi_out, lo_out);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult_signed();
        int lat, bc, hb, dz, dza;
        runOp(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if (lat !== 33) begin
            mismatched++;
            $display("[TB] FAIL mult_neg_latency got %0d want 33", lat);
        end
        compared++;
        if (bc !== 33) begin
            mismatched++;
            $display("[TB] FAIL mult_neg_busy_cycles got %0d want 33", bc);
        end
        compared++;
        if (hb !== 0) begin
            mismatched++;
            $display("[TB] FAIL mult_neg_hlw_vs_done got %0d bad cycles want 0", hb);
        end
        compared++;
        if ({hi_out, lo_out} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
            mismatched++;
            $display("[TB] FAIL mult_neg_result got %h/%h want ffffffff/ffffffeb", hi_out, lo_out);
        end
    endtask

    task automatic test_mult_extreme();
        int lat, bc, hb, dz, dza;
        runOp(1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if ({hi_out, lo_out} !== {32'h40000000, 32'h00000000}) begin
            mismatched++;
            $display("[TB] FAIL mult_min_sq got %h/%h want 40000000/00000000", hi_out, lo_out);
        end
    endtask

    task automatic test_div();
        int lat, bc, hb, dz, dza;
        runOp(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if (lat !== 33) begin
            mismatched++;
            $display("[TB] FAIL div_latency got %0d want 33", lat);
        end
        compared++;
        if ({hi_out, lo_out} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            mismatched++;
            $display("[TB] FAIL div_neg7_by_2 got %h/%h want ffffffff/fffffffd", hi_out, lo_out);
        end
        runOp(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if ({hi_out, lo_out} !== {32'h00000000, 32'h80000000}) begin
            mismatched++;
            $display("[TB] FAIL div_overflow got %h/%h want 00000000/80000000", hi_out, lo_out);
        end
        compared++;
        if (dz !== 0) begin
            mismatched++;
            $display("[TB] FAIL div_overflow_exception got %0d div_zero pulses want 0", dz);
        end
        runOp(1'b0, 1'b1, 32'h00002211, 32'h00000100, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if ({hi_out, lo_out} !== {32'h00000011, 32'h00000022}) begin
            mismatched++;
            $display("[TB] FAIL div_2211_by_100 got %h/%h want 00000011/00000022", hi_out, lo_out);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc, hb, dz, dza;
        runOp(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if (dza !== 0 || dz !== 1) begin
            mismatched++;
            $display("[TB] FAIL dz_pulse got at=%0d count=%0d want at=0 count=1", dza, dz);
        end
        compared++;
        if (lat !== -1) begin
            mismatched++;
            $display("[TB] FAIL dz_no_done got done at %0d want never", lat);
        end
        compared++;
        if (bc !== 0) begin
            mismatched++;
            $display("[TB] FAIL dz_no_busy got %0d busy cycles want 0", bc);
        end
        compared++;
        if ({hi_out, lo_out} !== {32'h00000011, 32'h00000022}) begin
            mismatched++;
            $display("[TB] FAIL dz_hilo_hold got %h/%h want 00000011/00000022", hi_out, lo_out);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, hb, dz, dza;
        int doneSeen;
        @(negedge clk);
        mult_start = 1'b1;
        op_a       = 32'd6;
        op_b       = 32'd6;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if ({busy, done, hi_lo_write, div_zero} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_flags got %b want 0000", {busy, done, hi_lo_write, div_zero});
        end
        compared++;
        if ({hi_out, lo_out} !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_hilo got %h/%h want 0/0", hi_out, lo_out);
        end
        doneSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        compared++;
        if (doneSeen !== 0) begin
            mismatched++;
            $display("[TB] FAIL midreset_abort got %0d done/busy cycles want 0", doneSeen);
        end
        runOp(1'b1, 1'b0, 32'd3, 32'd5, 1'b0, lat, bc, hb, dz, dza);
        compared++;
        if (lat !== 33) begin
            mismatched++;
            $display("[TB] FAIL post_reset_latency got %0d want 33", lat);
        end
        compared++;
        if ({hi_out, lo_out} !== {32'h0, 32'h0000000F}) begin
            mismatched++;
            $display("[TB] FAIL post_reset_mult got %h/%h want 00000000/0000000f", hi_out, lo_out);
        end
    endtask

    task automatic test_both_start();
        int lat, bc, hb, dz, dza;
        int extra;
        runOp(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, lat, bc, hb, dz, dza);
        compared++;
        if (lat !== 33) begin
            mismatched++;
            $display("[TB] FAIL both_latency got %0d want 33", lat);
        end
        compared++;
        if ({hi_out, lo_out} !== {32'h0, 32'h00000012}) begin
            mismatched++;
            $display("[TB] FAIL both_mult_wins got %h/%h want 00000000/00000012", hi_out, lo_out);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy || div_zero) extra++;
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL busy_start_ignored got %0d extra active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, hb, dz, dza;
        runOp(1'b1, 1'b0, 32'd4, 32'd4, 1'b0, lat, bc, hb, dz, dza);
        mult_start = 1'b1;
        op_a       = 32'd2;
        op_b       = 32'd2;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_finish_edge_ignored got busy=%b want 0", busy);
        end
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_idle_edge_accepted got busy=%b want 1", busy);
        end
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (lat !== 33 || {hi_out, lo_out} !== {32'h0, 32'h4}) begin
            mismatched++;
            $display("[TB] FAIL b2b_result got lat=%0d %h/%h want lat=33 00000000/00000004",
                     lat, hi_out, lo_out);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_mult_signed();
        test_mult_extreme();
        test_div();
        test_div_zero();
        test_reset_mid_op();
        test_both_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
